irq_sequencer: RTL and testbench

IRQ_SEQUENCER -- requirements
Module: irq_sequencer

---
 rtl/irq_sequencer_if.sv | 38 +++
 rtl/irq_sequencer.sv | 133 +++++++++++++
 tb/tb_irq_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/irq_sequencer_if.sv
// Signal bundle between the interrupt sequencer and its core-side
// environment (request lines, core status, entry strobe and vector).
//
// Handshake: interrupt_ask is a one-cycle strobe with no backpressure;
// the register group must take interrupt_pc / interrupt_ipc in the cycle
// it is high. irq_ret is a one-cycle pulse and is only acted on while a
// handler is in service; it is ignored in every other state.
interface irq_sequencer_if;
    logic [7:0]  irq_req;
    logic [31:0] sys;
    logic [31:0] pc;
    logic        pipe_busy;
    logic        pc_stop;
    logic        irq_ret;

    logic        interrupt_ask;
    logic [31:0] interrupt_pc;
    logic [31:0] interrupt_ipc;
    logic [7:0]  irq_ack;
    logic [7:0]  active_num;
    logic        in_service;
    logic [15:0] irq_total;
    logic [1:0]  state_dbg;

    // Core / register-group side
    modport master (
        output irq_req, sys, pc, pipe_busy, pc_stop, irq_ret,
        input  interrupt_ask, interrupt_pc, interrupt_ipc, irq_ack,
               active_num, in_service, irq_total, state_dbg
    );

    // Sequencer side
    modport slave (
        input  irq_req, sys, pc, pipe_busy, pc_stop, irq_ret,
        output interrupt_ask, interrupt_pc, interrupt_ipc, irq_ack,
               active_num, in_service, irq_total, state_dbg
    );
endinterface

// File: rtl/irq_sequencer.sv
// Interrupt entry sequencer: captures rising edges on eight request lines,
// waits for the pipeline to drain, then issues a one-cycle entry strobe
// with the vector and return address of the highest-priority pending line.
module irq_sequencer #(
    parameter logic [31:0] VECTOR_BASE        = 32'h0000_0100,
    parameter int unsigned VECTOR_STRIDE_LOG2 = 2
) (
    input  logic           clk,
    input  logic           all_rst_n,
    irq_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAIN   = 2'd1,
        ENTER   = 2'd2,
        SERVICE = 2'd3
    } state_t;

    state_t      state_q,      state_d;
    logic [7:0]  req_prev_q,   req_prev_d;
    logic [7:0]  pending_q,    pending_d;
    logic        ask_q,        ask_d;
    logic [31:0] vec_pc_q,     vec_pc_d;
    logic [31:0] ret_pc_q,     ret_pc_d;
    logic [7:0]  ack_q,        ack_d;
    logic [7:0]  active_q,     active_d;
    logic        in_service_q, in_service_d;
    logic [15:0] irq_total_q,  irq_total_d;

    logic [7:0]  rise;
    logic [7:0]  clr_mask;
    logic [2:0]  winner;

    // Only the global enable bit of sys matters here.
    logic unused_sys;
    assign unused_sys = ^bus.sys[31:1];

    // Lowest set pending index wins; scanning downward lets lower indices override.
    always_comb begin
        winner = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pending_q[i]) winner = 3'(i);
        end
    end

    // Next-state, pending bookkeeping and registered output values.
    always_comb begin
        rise         = bus.irq_req & ~req_prev_q;
        req_prev_d   = bus.irq_req;
        clr_mask     = 8'h00;
        state_d      = state_q;
        ask_d        = 1'b0;
        ack_d        = 8'h00;
        vec_pc_d     = vec_pc_q;
        ret_pc_d     = ret_pc_q;
        active_d     = active_q;
        in_service_d = in_service_q;
        irq_total_d  = irq_total_q;

        case (state_q)
            IDLE: begin
                if (bus.sys[0] && (pending_q != 8'h00)) state_d = DRAIN;
            end
            DRAIN: begin
                if (!bus.sys[0]) begin
                    state_d = IDLE;
                end else if (!bus.pipe_busy && !bus.pc_stop) begin
                    // Winner is chosen here so late higher-priority edges are honoured.
                    state_d     = ENTER;
                    ask_d       = 1'b1;
                    ack_d       = 8'h01 << winner;
                    clr_mask    = 8'h01 << winner;
                    active_d    = {5'd0, winner};
                    vec_pc_d    = VECTOR_BASE + (32'(winner) << VECTOR_STRIDE_LOG2);
                    ret_pc_d    = bus.pc;
                    irq_total_d = irq_total_q + 16'd1;
                end
            end
            ENTER: begin
                state_d      = SERVICE;
                in_service_d = 1'b1;
            end
            SERVICE: begin
                if (bus.irq_ret) begin
                    state_d      = IDLE;
                    in_service_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // A fresh edge on the line being entered re-arms it (set wins over clear).
        pending_d = (pending_q & ~clr_mask) | rise;
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge all_rst_n) begin
        if (!all_rst_n) begin
            state_q      <= IDLE;
            req_prev_q   <= 8'h00;
            pending_q    <= 8'h00;
            ask_q        <= 1'b0;
            vec_pc_q     <= 32'h0;
            ret_pc_q     <= 32'h0;
            ack_q        <= 8'h00;
            active_q     <= 8'h00;
            in_service_q <= 1'b0;
            irq_total_q  <= 16'h0;
        end else begin
            state_q      <= state_d;
            req_prev_q   <= req_prev_d;
            pending_q    <= pending_d;
            ask_q        <= ask_d;
            vec_pc_q     <= vec_pc_d;
            ret_pc_q     <= ret_pc_d;
            ack_q        <= ack_d;
            active_q     <= active_d;
            in_service_q <= in_service_d;
            irq_total_q  <= irq_total_d;
        end
    end

    assign bus.interrupt_ask = ask_q;
    assign bus.interrupt_pc  = vec_pc_q;
    assign bus.interrupt_ipc = ret_pc_q;
    assign bus.irq_ack       = ack_q;
    assign bus.active_num    = active_q;
    assign bus.in_service    = in_service_q;
    assign bus.irq_total     = irq_total_q;
    assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer: entry latency, priority, masking,
// nesting block, reset abort and counter wrap.
module tb_irq_sequencer;

    logic clk = 1'b0;
    logic all_rst_n;

    irq_sequencer_if bus ();

    irq_sequencer dut (
        .clk       (clk),
        .all_rst_n (all_rst_n),
        .bus       (bus)
    );

    // Clock
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ask(input int max, output int cycles);
        cycles = 0;
        while (!bus.interrupt_ask && cycles < max) begin
            tick();
            cycles++;
        end
    endtask

    task automatic end_service();
        bus.irq_ret = 1'b1;
        tick();
        bus.irq_ret = 1'b0;
    endtask

    task automatic check_entry(input string tag, input logic [7:0] ack, input logic [31:0] vec,
                               input logic [31:0] ipc, input logic [7:0] num, input logic [15:0] total);
        check({tag, "_ask"},   32'(bus.interrupt_ask), 32'd1);
        check({tag, "_ack"},   32'(bus.irq_ack),       32'(ack));
        check({tag, "_pc"},    bus.interrupt_pc,       vec);
        check({tag, "_ipc"},   bus.interrupt_ipc,      ipc);
        check({tag, "_num"},   32'(bus.active_num),    32'(num));
        check({tag, "_total"}, 32'(bus.irq_total),     32'(total));
    endtask

    initial begin
        int cyc;
        logic seen;

        bus.irq_req   = 8'h00;
        bus.sys       = 32'h0;
        bus.pc        = 32'h0;
        bus.pipe_busy = 1'b0;
        bus.pc_stop   = 1'b0;
        bus.irq_ret   = 1'b0;
        all_rst_n     = 1'b1;

        // Reset
        #2 all_rst_n = 1'b0;
        #1;
        check("rst_ask",   32'(bus.interrupt_ask), 32'd0);
        check("rst_pc",    bus.interrupt_pc,       32'd0);
        check("rst_total", 32'(bus.irq_total),     32'd0);
        check("rst_state", 32'(bus.state_dbg),     32'd0);
        tick();
        tick();
        #2 all_rst_n = 1'b1;
        bus.sys = 32'h1;
        bus.pc  = 32'h0001_0040;
        tick();
        tick();

        // Basic entry, nominal latency
        bus.irq_req[3] = 1'b1;
        wait_ask(10, cyc);
        check("basic_latency", 32'(cyc), 32'd3);
        check_entry("basic", 8'h08, 32'h0000_010C, 32'h0001_0040, 8'd3, 16'd1);
        tick();
        check("basic_ask_drop", 32'(bus.interrupt_ask), 32'd0);
        check("basic_ack_drop", 32'(bus.irq_ack),       32'd0);
        check("basic_insvc",    32'(bus.in_service),    32'd1);
        check("basic_pc_hold",  bus.interrupt_pc,       32'h0000_010C);
        end_service();
        check("basic_insvc_drop", 32'(bus.in_service), 32'd0);
        check("basic_idle",       32'(bus.state_dbg),  32'd0);
        bus.irq_req[3] = 1'b0;
        tick();

        // Priority during drain; irq_ret ignored in DRAIN
        bus.pipe_busy  = 1'b1;
        bus.irq_req[5] = 1'b1;
        tick();
        tick();
        check("prio_drain", 32'(bus.state_dbg), 32'd1);
        bus.irq_ret = 1'b1;
        tick();
        bus.irq_ret = 1'b0;
        check("prio_ret_ignored", 32'(bus.state_dbg), 32'd1);
        bus.irq_req[1] = 1'b1;
        tick();
        check("prio_hold_ask", 32'(bus.interrupt_ask), 32'd0);
        bus.pipe_busy = 1'b0;
        wait_ask(10, cyc);
        check_entry("prio1", 8'h02, 32'h0000_0104, 32'h0001_0040, 8'd1, 16'd2);
        tick();
        end_service();
        wait_ask(10, cyc);
        check_entry("prio5", 8'h20, 32'h0000_0114, 32'h0001_0040, 8'd5, 16'd3);
        tick();
        end_service();
        bus.irq_req = 8'h00;
        tick();

        // Masking
        bus.sys        = 32'h0;
        bus.irq_req[0] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen = seen | bus.interrupt_ask;
        end
        check("mask_no_ask", 32'(seen),          32'd0);
        check("mask_idle",   32'(bus.state_dbg), 32'd0);
        bus.sys = 32'h1;
        wait_ask(10, cyc);
        check_entry("mask", 8'h01, 32'h0000_0100, 32'h0001_0040, 8'd0, 16'd4);
        tick();

        // Nesting blocked; pc_stop holds DRAIN
        bus.irq_req[0] = 1'b0;
        tick();
        bus.irq_req[0] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen = seen | bus.interrupt_ask;
        end
        check("nest_no_ask", 32'(seen),           32'd0);
        check("nest_insvc",  32'(bus.in_service), 32'd1);
        bus.pc_stop = 1'b1;
        bus.pc      = 32'h0002_0000;
        end_service();
        for (int i = 0; i < 4; i++) tick();
        check("stop_drain",  32'(bus.state_dbg),     32'd1);
        check("stop_no_ask", 32'(bus.interrupt_ask), 32'd0);
        bus.pc_stop = 1'b0;
        wait_ask(10, cyc);
        check_entry("nest", 8'h01, 32'h0000_0100, 32'h0002_0000, 8'd0, 16'd5);
        tick();
        end_service();
        bus.irq_req = 8'h00;
        tick();

        // Reset mid-DRAIN
        bus.pipe_busy  = 1'b1;
        bus.irq_req[4] = 1'b1;
        tick();
        tick();
        tick();
        check("rstmid_drain", 32'(bus.state_dbg), 32'd1);
        #2 all_rst_n = 1'b0;
        #1;
        check("rstmid_pc",    bus.interrupt_pc,        32'd0);
        check("rstmid_ipc",   bus.interrupt_ipc,       32'd0);
        check("rstmid_total", 32'(bus.irq_total),      32'd0);
        check("rstmid_state", 32'(bus.state_dbg),      32'd0);
        bus.irq_req   = 8'h04;
        bus.pipe_busy = 1'b0;
        tick();
        tick();
        #2 all_rst_n = 1'b1;
        wait_ask(10, cyc);
        check_entry("rstmid", 8'h04, 32'h0000_0108, 32'h0002_0000, 8'd2, 16'd1);
        tick();
        end_service();
        bus.irq_req = 8'h00;
        tick();

        // Counter wrap
        force dut.irq_total_q = 16'hFFFF;
        #1;
        release dut.irq_total_q;
        check("wrap_preload", 32'(bus.irq_total), 32'h0000_FFFF);
        bus.irq_req[2] = 1'b1;
        wait_ask(10, cyc);
        check_entry("wrap", 8'h04, 32'h0000_0108, 32'h0002_0000, 8'd2, 16'h0000);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
